// File: rtl/shift_add_mult4_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width
// and the controller state encoding.
package shift_add_mult4_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult4_if.sv
// Request/result bundle of the multiplier.
// Handshake: start is sampled on a rising edge only while busy=0; done is a
// one-cycle pulse and product holds until the next done.
interface shift_add_mult4_if
  import shift_add_mult4_pkg::*;
#(
  parameter int W = DEF_WIDTH
);

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/shift_add_mult4_nibble_adder.sv
// Purely combinational ripple-carry adder used for the partial-product add.
module nibble_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_sum[i]   = i_x[i] ^ i_y[i] ^ w_c[i];
    assign w_c[i + 1] = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one conditional add and one
// right shift of {acc,q} per clock, WIDTH iterations per product.
module shift_add_mult4
  import shift_add_mult4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_mult4_if.slave      bus,
  output state_t                o_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_mcand;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_load;
  logic                 w_step;
  logic                 w_last;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_pp_sum;
  logic                 w_pp_c;
  logic [2*WIDTH-1:0]   w_shifted;

  nibble_adder #(.WIDTH(WIDTH)) u_add (
    .i_x    (r_acc),
    .i_y    (r_mcand),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The carry-out is shifted into the top of acc so no product bit is lost.
  assign w_pp_sum  = r_q[0] ? w_sum : r_acc;
  assign w_pp_c    = r_q[0] & w_cout;
  assign w_shifted = {w_pp_c, w_pp_sum, r_q[WIDTH-1:1]};
  assign w_last    = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        // A new request is taken here directly so back-to-back products
        // need no idle cycle in between.
        if (bus.start) begin
          w_load = 1'b1;
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_q       <= '0;
      r_mcand   <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_mcand <= bus.a;
      r_q     <= bus.b;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_step) begin
      {r_acc, r_q} <= w_shifted;
      r_count      <= r_count + CW'(1);
      if (w_last) r_product <= w_shifted;
    end
  end

  assign bus.busy    = (r_state == ST_RUN);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.product = r_product;
  assign o_state     = r_state;

endmodule

// File: tb/tb_shift_add_mult4.sv
// Self-checking bench for shift_add_mult4: directed cases, back-to-back,
// asynchronous reset mid-run and an exhaustive operand sweep.
module tb_shift_add_mult4;
  import shift_add_mult4_pkg::*;

  logic   clk;
  logic   rst;
  state_t state;

  shift_add_mult4_if #(.W(4)) bus ();

  shift_add_mult4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] hold_prod;
  logic       prev_done;
  int         n_tests;
  int         n_fail;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops the expected product on every done, checks the product
  // register holds between completions and done never lasts two cycles.
  always @(negedge clk) begin
    if (rst) begin
      prev_done <= 1'b0;
    end else begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", {15'd0, bus.done}, 16'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check_eq("product", {8'd0, bus.product}, {8'd0, e});
          hold_prod = e;
        end
      end else begin
        check_eq("product_hold", {8'd0, bus.product}, {8'd0, hold_prod});
      end
      check_eq("done_pulse", {15'd0, prev_done & bus.done}, 16'd0);
      prev_done <= bus.done;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge right after the start edge; returns at the negedge
  // where done is visible. edges counts the start edge as edge 1.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges       = 1;
    busy_cycles = 0;
    while (!bus.done && edges <= 20) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("done_seen", {15'd0, bus.done}, 16'd1);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b);
    int edges;
    int busy_cycles;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    exp_q.push_back(8'(a * b));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 4'(~a);
    bus.b     = 4'(~b);
    wait_done(edges, busy_cycles);
    check_eq("latency", 16'(edges), 16'd5);
    check_eq("busy_cycles", 16'(busy_cycles), 16'd4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    int busy_cycles;
    int dones;
    n_tests   = 0;
    n_fail    = 0;
    hold_prod = 8'h00;
    prev_done = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.b     = 4'd0;
    idle(3);
    check_eq("rst_busy", {15'd0, bus.busy}, 16'd0);
    check_eq("rst_done", {15'd0, bus.done}, 16'd0);
    check_eq("rst_product", {8'd0, bus.product}, 16'd0);
    check_eq("rst_state", {14'd0, state}, {14'd0, ST_IDLE});
    rst = 1'b0;
    idle(2);

    // Directed cases, including the maximum product 8'hE1.
    run_op(4'd15, 4'd15);
    idle(1);
    check_eq("done_drops", {15'd0, bus.done}, 16'd0);
    run_op(4'd9, 4'd6);
    idle(1);
    run_op(4'd0, 4'd13);
    idle(2);
    run_op(4'd7, 4'd1);
    idle(1);

    // Operand change plus held start during RUN: ignored until DONE,
    // then accepted back-to-back.
    bus.a     = 4'd3;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hE1);
    @(posedge clk);
    @(negedge clk);
    bus.a = 4'd15;
    bus.b = 4'd15;
    wait_done(edges, busy_cycles);
    check_eq("b2b_latency1", 16'(edges), 16'd5);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("b2b_no_idle", {15'd0, bus.busy}, 16'd1);
    wait_done(edges, busy_cycles);
    check_eq("b2b_latency2", 16'(edges), 16'd5);
    idle(2);

    // Asynchronous reset in the second RUN cycle of 12*12.
    bus.a     = 4'd12;
    bus.b     = 4'd12;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", {15'd0, bus.busy}, 16'd0);
    check_eq("arst_done", {15'd0, bus.done}, 16'd0);
    check_eq("arst_product", {8'd0, bus.product}, 16'd0);
    hold_prod = 8'h00;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_eq("arst_no_done", 16'(dones), 16'd0);
    run_op(4'd2, 4'd3);
    idle(1);

    // Exhaustive sweep with random idle gaps.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b));
        idle($urandom_range(0, 2));
      end
    end

    idle(3);
    check_eq("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
